gcd_sequencer: RTL
==================

Name: gcd_sequencer

Overview:
Initiator-side front end for the Euclidean GCD core. It accepts operand pairs on a valid/ready input stream and drives the core's start/operand/done handshake. It returns each result on a valid/ready output stream and recovers a hung core with a watchdog abort. It sits between the system datapath and the GCD core, one job in flight at a time.

Parameters:
W, 32, operand and result width (must match core)
TIMEOUT, 4096, max cycles in WAIT before abort (>=2)
CW, 13, watchdog counter width (2^CW > TIMEOUT)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept a pair
in_a  input  W  operand a
in_b  input  W  operand b
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  W  gcd(a,b), or 0 on timeout
out_timeout  output  1  qualifies out_result: job aborted
core_start  output  1  start pulse to core
core_opa  output  W  operand a to core
core_opb  output  W  operand b to core
core_resetn  output  1  active-low reset to core
core_done  input  1  core done level
core_result  input  W  core result, valid while core_done=1

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_timeout=0, core_start=0, core_opa=core_opb=0, counter=0.
- core_resetn = ~reset & ~abort_reg. abort_reg is a registered flag, high only in ABORT.
- core_opa/core_opb come from capture registers. They are held stable from START until the next accepted pair.
- in_ready = (state==IDLE). out_valid = (state==RESP).
- IDLE: on in_valid&in_ready, capture a and b.
  - If b==0: out_result<=a, out_timeout<=0, go to RESP. No core transaction, core_start never asserts.
  - Otherwise go to START.
- START: core_start=1 for exactly this one cycle. Next state ARM.
- ARM: core_start=0. core_done is ignored because it is stale from the previous job; the core clears it on the cycle after start. Clear counter. Next state WAIT.
- WAIT:
  - If core_done=1: out_result<=core_result, out_timeout<=0, go to RESP.
  - Else if counter==TIMEOUT-1: out_result<=0, out_timeout<=1, go to ABORT.
  - Else counter+1.
  - core_done takes priority over timeout on the same cycle.
- ABORT: abort_reg=1, so core_resetn=0 for exactly one cycle. Next state RESP.
- RESP: out_valid=1. out_result and out_timeout are held stable until out_ready=1, then go to IDLE.
- Throughput: an accept happens at most every 2 cycles (RESP→IDLE).
- Spacing: core_start is always separated by >=3 low cycles, which satisfies the core's start edge detect.
- Latency for the b==0 bypass: out_valid is asserted in the cycle after accept.
- Latency for a core job: accept at cycle 0, core_start at cycle 1, WAIT from cycle 3. out_valid follows the first core_done sample in WAIT by 1 cycle.
- Timeout: in_valid, in_b and core_done are don't-care outside their sampling states.
- Reset mid-operation: the job is lost with no output. core_resetn is low while reset is high.

Test Plan:
- Normal job: a=48, b=18 accepted at cycle 0 → core_start high only at cycle 1, core_opa=48, core_opb=18. Result: out_valid with out_result=6, out_timeout=0.
- b==0 bypass: a=7, b=0 → out_valid at cycle 1 with out_result=7, out_timeout=0. core_start stays 0.
- Stale done: job (12,8) → 4, then job (35,21) while the core holds done=1 through ARM. Second result is 7, not 4.
- Backpressure: after (48,18), hold out_ready=0 for 5 cycles. out_valid=1 and out_result=6 stay stable, in_ready=0 throughout. Accept on release, in_ready=1 next cycle.
- Timeout: TIMEOUT=16, core_done tied 0, job (9,6). Exactly 16 WAIT cycles, then core_resetn=0 for one cycle. out_valid with out_result=0, out_timeout=1. A following job (9,6) with a working core returns 3.
- Reset in WAIT: assert reset for 2 cycles mid-job. Outputs go to reset values immediately, core_resetn=0 during reset, in_ready=1 after release, no out_valid for the lost job.

Source files
------------

// File: rtl/gcd_sequencer.sv
// gcd_sequencer: initiator-side front end for the Euclidean GCD core.
// Accepts one operand pair at a time, runs it through the core (or bypasses
// the core when b==0), and returns the result on a valid/ready stream. A
// watchdog aborts a hung core with a one-cycle reset pulse and reports a
// timeout result of zero.
module gcd_sequencer #(
    parameter int W       = 32,
    parameter int TIMEOUT = 4096,
    parameter int CW      = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_timeout,
    output logic         core_start,
    output logic [W-1:0] core_opa,
    output logic [W-1:0] core_opb,
    output logic         core_resetn,
    input  logic         core_done,
    input  logic [W-1:0] core_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_WAIT,
        S_ABORT,
        S_RESP
    } state_t;

    // Last watchdog count value; reaching it in WAIT without done aborts.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  result_q, result_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q, start_d;
    logic          abort_q, abort_d;

    // State and datapath registers; start/abort are registered so the core
    // sees glitch-free control pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state logic: capture, core handshake, watchdog and response hold.
    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opa_d = in_a;
                    opb_d = in_b;
                    if (in_b == '0) begin
                        // gcd(a,0)=a: answer directly, core is never started.
                        result_d  = in_a;
                        timeout_d = 1'b0;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: state_d = S_ARM;
            S_ARM: begin
                // core_done is still the previous job's level here; skip it.
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    result_d  = core_result;
                    timeout_d = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_ABORT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ABORT: state_d = S_RESP;
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_START);
        abort_d = (state_d == S_ABORT);
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_RESP);
    assign out_result  = result_q;
    assign out_timeout = timeout_q;
    assign core_start  = start_q;
    assign core_opa    = opa_q;
    assign core_opb    = opb_q;
    assign core_resetn = ~reset & ~abort_q;

endmodule
